// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and default widths for the APB slave bridge
package apb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int WAIT_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb_wait_counter.sv
// rtl/apb_wait_counter.sv - loadable wait-state down-counter with zero flag
module apb_wait_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/apb_slave.sv
// rtl/apb_slave.sv - APB slave bridge to a simple memory port with programmable wait states
module apb_slave
    import apb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int WAIT_W = WAIT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sel,
    input  logic              enable,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [WAIT_W-1:0] wait_cycles,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wren,
    output logic              mem_rden
);

    apb_state_t        state;
    apb_state_t        state_next;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;
    logic [WAIT_W-1:0] cnt;
    logic              setup_phase;

    apb_wait_counter #(.W(WAIT_W)) u_wait_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (wait_cycles),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign setup_phase = sel && !enable;

    // The setup phase is decoded in the same cycle it appears on the bus, so the
    // first enable cycle already sees ACCESS. SETUP follows a completion and opens
    // a back-to-back transfer when sel stays high with enable low.
    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state)
            IDLE, SETUP: begin
                if (setup_phase) begin
                    state_next = ACCESS;
                    cnt_load   = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            ACCESS: begin
                if (!sel || !enable) begin
                    state_next = IDLE;
                end else if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    state_next = SETUP;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Gating with reset_n keeps every strobe low while reset is asserted mid-transfer.
    assign ready     = reset_n && (state == ACCESS) && cnt_zero && sel && enable;
    assign mem_wren  = ready && write;
    assign mem_rden  = ready && !write;
    assign rdata     = mem_rden ? mem_rdata : '0;
    assign mem_addr  = addr;
    assign mem_wdata = wdata;

endmodule

// File: tb/tb_apb_slave.sv
// tb/tb_apb_slave.sv - directed self-checking bench for apb_slave
module tb_apb_slave;

    logic        clk;
    logic        reset_n;
    logic        sel;
    logic        enable;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wait_cycles;
    logic [31:0] rdata;
    logic        ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_wren;
    logic        mem_rden;

    logic [31:0] mem [16];

    int checks = 0;
    int errors = 0;

    apb_slave #(.ADDR_W(32), .DATA_W(32), .WAIT_W(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sel         (sel),
        .enable      (enable),
        .write       (write),
        .addr        (addr),
        .wdata       (wdata),
        .wait_cycles (wait_cycles),
        .rdata       (rdata),
        .ready       (ready),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_wren    (mem_wren),
        .mem_rden    (mem_rden)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wren) mem[mem_addr[5:2]] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr[5:2]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ready"}, {31'd0, ready}, 32'd0);
        check({tag, "_wren"}, {31'd0, mem_wren}, 32'd0);
        check({tag, "_rden"}, {31'd0, mem_rden}, 32'd0);
        check({tag, "_rdata"}, rdata, 32'd0);
    endtask

    // One full transfer; wc_mid is put on wait_cycles during the access phase.
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input int n, input logic [31:0] exp_rd, input logic hold,
                        input logic [3:0] wc_mid);
        logic last;
        sel = 1'b1; enable = 1'b0; write = wr; addr = a; wdata = d;
        wait_cycles = n[3:0];
        @(negedge clk);
        check_quiet("setup");
        @(posedge clk); #1;
        enable = 1'b1;
        wait_cycles = wc_mid;
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge clk);
            last = (k == n + 1);
            check($sformatf("ready_n%0d_c%0d", n, k), {31'd0, ready}, {31'd0, last});
            check($sformatf("wren_n%0d_c%0d", n, k), {31'd0, mem_wren}, {31'd0, last && wr});
            check($sformatf("rden_n%0d_c%0d", n, k), {31'd0, mem_rden}, {31'd0, last && !wr});
            check($sformatf("rdata_n%0d_c%0d", n, k), rdata, (last && !wr) ? exp_rd : 32'd0);
            @(posedge clk); #1;
        end
        enable = 1'b0;
        sel = hold;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        reset_n = 1'b0; sel = 1'b1; enable = 1'b1; write = 1'b1;
        addr = 32'h4; wdata = 32'hFFFF_FFFF; wait_cycles = 4'd0;

        // Reset held 3 cycles with the bus active
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_quiet("reset");
        end
        @(posedge clk); #1;
        reset_n = 1'b1; sel = 1'b0; enable = 1'b0;
        @(negedge clk);
        check_quiet("post_reset");
        @(posedge clk); #1;

        // Zero-wait write and read
        xfer(1'b1, 32'h4, 32'hA5A5_A5A5, 0, 32'd0, 1'b0, 4'd0);
        check("mem4_write", mem[1], 32'hA5A5_A5A5);
        xfer(1'b0, 32'h4, 32'd0, 0, 32'hA5A5_A5A5, 1'b0, 4'd0);

        // Five wait states
        xfer(1'b1, 32'h8, 32'h1234_5678, 5, 32'd0, 1'b0, 4'd5);
        check("mem8_write", mem[2], 32'h1234_5678);
        xfer(1'b0, 32'h8, 32'd0, 5, 32'h1234_5678, 1'b0, 4'd5);

        // wait_cycles changed during the access phase must be ignored
        xfer(1'b1, 32'hC, 32'hDEAD_BEEF, 1, 32'd0, 1'b0, 4'd15);
        xfer(1'b0, 32'hC, 32'd0, 1, 32'hDEAD_BEEF, 1'b0, 4'd0);
        xfer(1'b1, 32'h10, 32'hCAFE_F00D, 3, 32'd0, 1'b0, 4'd0);
        xfer(1'b0, 32'h10, 32'd0, 3, 32'hCAFE_F00D, 1'b0, 4'd7);

        // Back-to-back with sel held between transfers
        xfer(1'b1, 32'h14, 32'h0BAD_F00D, 0, 32'd0, 1'b1, 4'd0);
        xfer(1'b0, 32'h14, 32'd0, 2, 32'h0BAD_F00D, 1'b0, 4'd2);

        // Maximum wait count, no wrap
        xfer(1'b1, 32'h18, 32'h5A5A_0001, 15, 32'd0, 1'b0, 4'd0);
        check("mem18_write", mem[6], 32'h5A5A_0001);

        // enable without a setup phase is ignored
        sel = 1'b1; enable = 1'b1; write = 1'b1; addr = 32'h4; wdata = 32'h9999_9999;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_quiet("no_setup");
            @(posedge clk); #1;
        end
        sel = 1'b0; enable = 1'b0;
        @(posedge clk); #1;
        check("mem4_no_setup", mem[1], 32'hA5A5_A5A5);

        // sel dropped mid-wait
        sel = 1'b1; enable = 1'b0; write = 1'b1; addr = 32'h4; wdata = 32'h1111_1111;
        wait_cycles = 4'd3;
        @(posedge clk); #1;
        enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_quiet("abort_wait");
            @(posedge clk); #1;
        end
        sel = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_quiet("abort_drop");
            @(posedge clk); #1;
        end
        sel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_quiet("abort_idle");
            @(posedge clk); #1;
        end
        sel = 1'b0; enable = 1'b0;
        check("mem4_abort", mem[1], 32'hA5A5_A5A5);

        // Reset mid-access
        sel = 1'b1; enable = 1'b0; write = 1'b1; addr = 32'h8; wdata = 32'h2222_2222;
        wait_cycles = 4'd3;
        @(posedge clk); #1;
        enable = 1'b1;
        @(negedge clk);
        check_quiet("rst_mid_c1");
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(negedge clk);
        check_quiet("rst_mid_in");
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_quiet("rst_mid_after");
            @(posedge clk); #1;
        end
        sel = 1'b0; enable = 1'b0;
        check("mem8_reset_abort", mem[2], 32'h1234_5678);
        xfer(1'b0, 32'h8, 32'd0, 0, 32'h1234_5678, 1'b0, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
